rotary_decoder_multi: RTL and testbench
=======================================

// Module: rotary_decoder_multi
// PURPOSE
//  Parametrised multi-channel successor to the single-encoder decoder: synchronises, debounces and
//  full-quadrature-decodes CHANNELS rotary encoders (active-low clk/dt outputs) in parallel.
//  Each channel emits one-cycle up/dn pulses per detent, keeps a position counter and flags illegal
//  Gray transitions. Sits between the encoder pads and the WS2812B colour/brightness control logic.
// PARAMETERS
//  CHANNELS         2      number of independent encoders
//  SYNC_STAGES      2      synchroniser flops per raw input (>=2)
//  DEBOUNCE_CYCLES  40000  cycles an input must hold a new level before it is accepted (1 ms @ 40 MHz, >=1)
//  CNT_WIDTH        8      position counter width per channel
//  WRAP             1      1: position wraps modulo 2^CNT_WIDTH; 0: saturates at 0 / 2^CNT_WIDTH-1
// PORTS
//  clk          in   1                   40 MHz system clock
//  res_n        in   1                   asynchronous active-low reset
//  rotary_clk   in   CHANNELS            raw encoder "clk" outputs, active low, asynchronous
//  rotary_dt    in   CHANNELS            raw encoder "dt" outputs, active low, asynchronous
//  err_clr      in   1                   one-cycle pulse clears all err bits
//  rotation_up  out  CHANNELS            one-cycle pulse per clockwise detent
//  rotation_dn  out  CHANNELS            one-cycle pulse per counter-clockwise detent
//  position     out  CHANNELS*CNT_WIDTH  channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//  err          out  CHANNELS            sticky: illegal quadrature transition seen
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops and filtered {clk,dt} = 2'b11 (idle); debounce counters,
//   sub-step accumulators, rotation_up/dn, position, err all 0. All channels fully independent.
//  Sync: SYNC_STAGES-flop chain per raw input; only the last stage feeds the filter.
//  Debounce per input: if synced != filtered, counter++; when counter reaches DEBOUNCE_CYCLES-1 with
//   synced still != filtered, filtered <= synced and counter <= 0. Any cycle synced == filtered: counter <= 0.
//   Glitch shorter than DEBOUNCE_CYCLES cycles never reaches filtered.
//  Quadrature FSM on filtered q={clk,dt}, registered previous value qp, signed 3-bit acc, flag bad:
//   CW sequence 11->10->00->01->11 (dt falls first); CCW 11->01->00->10->11.
//   q==qp: no action. One-bit change in CW direction: acc+1; CCW direction: acc-1.
//   Two-bit change (11<->00, 10<->01): illegal -> err[i]<=1, bad<=1.
//   On entering 11: acc==+4 && !bad -> rotation_up pulse; acc==-4 && !bad -> rotation_dn pulse;
//    otherwise (partial turn, reversal, bad) no pulse. acc<=0, bad<=0 on every entry into 11.
//   Latency: filtered change into 11 at cycle t -> pulse high exactly cycle t+1, low at t+2.
//   up and dn never high together on one channel.
//  Position: same cycle as pulse; up: +1, dn: -1. WRAP=1: 2^W-1 +1 -> 0, 0 -1 -> 2^W-1.
//   WRAP=0: hold at 2^W-1 on up, hold at 0 on dn (pulse still emitted).
//  err: err_clr clears all bits; illegal transition in same cycle as err_clr -> that bit set (set wins).
//  Raw input to filtered latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles for a clean edge.
// TESTING (bench uses DEBOUNCE_CYCLES=4, CNT_WIDTH=4, CHANNELS=2 unless noted)
//  Ch0 clean CW detent, each step held 20 cycles -> one rotation_up[0] pulse 1 cycle wide, position0 0->1,
//   dn/err stay 0, ch1 outputs unchanged.
//  Ch1 CCW detent from reset, WRAP=1 -> rotation_dn[1] pulse, position1 0->15; WRAP=0 -> pulse, position1 stays 0.
//  Ch0 dt low 3 cycles then high (glitch < DEBOUNCE_CYCLES) -> filtered unchanged, no pulse, no err.
//  Ch0 11->10->00 then back 00->10->11 (reversal) -> no pulse, position unchanged, err 0.
//  Ch0 forced 11->00->11 (both inputs same cycle) -> err[0]=1, no pulse; err_clr coincident with
//   second illegal jump -> err[0] stays 1; later lone err_clr -> err[0]=0.
//  Both channels CW simultaneously, res_n asserted mid-sequence -> all outputs 0 immediately;
//   after release, a full CW detent on each -> one up pulse each, positions = 1.

Source files
------------

// File: rtl/rotary_decoder_multi.sv
`timescale 1ns/1ps
// rotary_decoder_multi: per-channel synchroniser, debounce filter and full-quadrature decoder for
// CHANNELS active-low rotary encoders, producing detent pulses, a position counter and a sticky error.
module rotary_decoder_multi #(
   parameter int CHANNELS        = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 40000,
   parameter int CNT_WIDTH       = 8,
   parameter bit WRAP            = 1'b1
) (
   input  logic                          clk,
   input  logic                          res_n,
   input  logic [CHANNELS-1:0]           rotary_clk,
   input  logic [CHANNELS-1:0]           rotary_dt,
   input  logic                          err_clr,
   output logic [CHANNELS-1:0]           rotation_up,
   output logic [CHANNELS-1:0]           rotation_dn,
   output logic [CHANNELS*CNT_WIDTH-1:0] position,
   output logic [CHANNELS-1:0]           err
);

   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0]       DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] POS_MAX = '1;

   typedef enum logic [1:0] {
      PH_IDLE = 2'b11,
      PH_A    = 2'b10,
      PH_B    = 2'b00,
      PH_C    = 2'b01
   } phase_t;

   // Place of a phase along the clockwise cycle; index difference 1 (mod 4) is a CW step, 3 is CCW.
   function automatic logic [1:0] cw_index(input logic [1:0] ph);
      logic [1:0] r;
      case (ph)
         2'b11:   r = 2'd0;
         2'b10:   r = 2'd1;
         2'b00:   r = 2'd2;
         default: r = 2'd3;
      endcase
      return r;
   endfunction

   // Returns {filtered, counter}: accept the synced level once it has differed for DEBOUNCE_CYCLES cycles.
   function automatic logic [DBW:0] debounce(input logic synced, input logic filt,
                                             input logic [DBW-1:0] cnt);
      logic [DBW:0] r;
      r = {filt, {DBW{1'b0}}};
      if (synced != filt) begin
         if (cnt == DB_LAST) begin
            r = {synced, {DBW{1'b0}}};
         end else begin
            r = {filt, cnt + DBW'(1)};
         end
      end
      return r;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] pos_step(input logic [CNT_WIDTH-1:0] pos, input logic up);
      logic [CNT_WIDTH-1:0] r;
      r = pos;
      if (up) begin
         if (WRAP || (pos != POS_MAX)) r = pos + CNT_WIDTH'(1);
      end else begin
         if (WRAP || (pos != '0)) r = pos - CNT_WIDTH'(1);
      end
      return r;
   endfunction

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_clk_q, sync_dt_q;
      logic [DBW-1:0]         db_clk_q, db_clk_d, db_dt_q, db_dt_d;
      logic                   filt_clk_q, filt_clk_d, filt_dt_q, filt_dt_d;
      phase_t                 qp_q, qp_d;
      logic [1:0]             q, step;
      logic signed [2:0]      acc_q, acc_d;
      logic signed [3:0]      acc_sum;
      logic                   bad_q, bad_d, illegal;
      logic                   up_q, up_d, dn_q, dn_d, err_q, err_d;
      logic [CNT_WIDTH-1:0]   pos_q, pos_d;

      always_ff @(posedge clk or negedge res_n) begin
         if (!res_n) begin
            sync_clk_q <= '1;
            sync_dt_q  <= '1;
            db_clk_q   <= '0;
            db_dt_q    <= '0;
            filt_clk_q <= 1'b1;
            filt_dt_q  <= 1'b1;
            qp_q       <= PH_IDLE;
            acc_q      <= '0;
            bad_q      <= 1'b0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            err_q      <= 1'b0;
            pos_q      <= '0;
         end else begin
            sync_clk_q <= {sync_clk_q[SYNC_STAGES-2:0], rotary_clk[ch]};
            sync_dt_q  <= {sync_dt_q[SYNC_STAGES-2:0], rotary_dt[ch]};
            db_clk_q   <= db_clk_d;
            db_dt_q    <= db_dt_d;
            filt_clk_q <= filt_clk_d;
            filt_dt_q  <= filt_dt_d;
            qp_q       <= qp_d;
            acc_q      <= acc_d;
            bad_q      <= bad_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
         end
      end

      always_comb begin
         {filt_clk_d, db_clk_d} = debounce(sync_clk_q[SYNC_STAGES-1], filt_clk_q, db_clk_q);
         {filt_dt_d, db_dt_d}   = debounce(sync_dt_q[SYNC_STAGES-1], filt_dt_q, db_dt_q);
      end

      assign q    = {filt_clk_q, filt_dt_q};
      assign step = cw_index(q) - cw_index(qp_q);

      // The accumulator is checked one step ahead in 4 bits, since +4/-4 does not fit the 3-bit store.
      always_comb begin
         qp_d    = phase_t'(q);
         acc_d   = acc_q;
         acc_sum = {acc_q[2], acc_q};
         bad_d   = bad_q;
         illegal = 1'b0;
         up_d    = 1'b0;
         dn_d    = 1'b0;
         err_d   = err_q & ~err_clr;
         if (q != qp_q) begin
            case (step)
               2'd1:    acc_sum = acc_sum + 4'sd1;
               2'd3:    acc_sum = acc_sum - 4'sd1;
               default: illegal = 1'b1;
            endcase
            acc_d = acc_sum[2:0];
            if (illegal) begin
               err_d = 1'b1;
               bad_d = 1'b1;
            end
            if (qp_d == PH_IDLE) begin
               up_d  = !bad_q && !illegal && (acc_sum == 4'sd4);
               dn_d  = !bad_q && !illegal && (acc_sum == -4'sd4);
               acc_d = '0;
               bad_d = 1'b0;
            end
         end
         pos_d = pos_q;
         if (up_d) begin
            pos_d = pos_step(pos_q, 1'b1);
         end else if (dn_d) begin
            pos_d = pos_step(pos_q, 1'b0);
         end
      end

      assign rotation_up[ch]                         = up_q;
      assign rotation_dn[ch]                         = dn_q;
      assign err[ch]                                 = err_q;
      assign position[ch*CNT_WIDTH +: CNT_WIDTH]     = pos_q;
   end

endmodule

// File: tb/tb_rotary_decoder_multi.sv
`timescale 1ns/1ps
// Bench for rotary_decoder_multi: a wrapping and a saturating instance share the same encoder inputs.
module tb_rotary_decoder_multi;

   logic       clk = 1'b0;
   logic       res_n = 1'b1;
   logic [1:0] rclk = 2'b11;
   logic [1:0] rdt = 2'b11;
   logic       err_clr = 1'b0;
   logic [1:0] up_w, dn_w, err_w, up_s, dn_s, err_s;
   logic [7:0] pos_w, pos_s;

   always #5 clk = ~clk;

   rotary_decoder_multi #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(4), .WRAP(1'b1))
      dut_wrap (.clk(clk), .res_n(res_n), .rotary_clk(rclk), .rotary_dt(rdt), .err_clr(err_clr),
                .rotation_up(up_w), .rotation_dn(dn_w), .position(pos_w), .err(err_w));

   rotary_decoder_multi #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(4), .WRAP(1'b0))
      dut_sat (.clk(clk), .res_n(res_n), .rotary_clk(rclk), .rotary_dt(rdt), .err_clr(err_clr),
               .rotation_up(up_s), .rotation_dn(dn_s), .position(pos_s), .err(err_s));

   // Pulse counters since the last reset, plus a sticky flag for up and dn seen together.
   int   up_cw [2];
   int   dn_cw [2];
   int   up_cs [2];
   int   dn_cs [2];
   logic both_seen = 1'b0;

   always @(negedge clk or negedge res_n) begin
      if (!res_n) begin
         for (int i = 0; i < 2; i++) begin
            up_cw[i] <= 0; dn_cw[i] <= 0; up_cs[i] <= 0; dn_cs[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            up_cw[i] <= up_cw[i] + int'(up_w[i]);
            dn_cw[i] <= dn_cw[i] + int'(dn_w[i]);
            up_cs[i] <= up_cs[i] + int'(up_s[i]);
            dn_cs[i] <= dn_cs[i] + int'(dn_s[i]);
            if ((up_w[i] && dn_w[i]) || (up_s[i] && dn_s[i])) both_seen <= 1'b1;
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pk(input int u1, input int d1, input int u0, input int d0);
      logic [31:0] r;
      r = {u1[7:0], d1[7:0], u0[7:0], d0[7:0]};
      return r;
   endfunction

   function automatic logic [7:0] pk_pos(input int p1, input int p0);
      logic [7:0] r;
      r = {p1[3:0], p0[3:0]};
      return r;
   endfunction

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ph(input int ch, input logic [1:0] ph);
      rclk[ch] = ph[1];
      rdt[ch]  = ph[0];
   endtask

   task automatic chk_all(input string nm, input logic [7:0] pw, input logic [7:0] ps,
                          input logic [1:0] er, input logic [31:0] cnt);
      chk({nm, "_pos_wrap"}, pos_w, pw);
      chk({nm, "_pos_sat"}, pos_s, ps);
      chk({nm, "_err_wrap"}, err_w, er);
      chk({nm, "_err_sat"}, err_s, er);
      chk({nm, "_cnt_wrap"}, pk(up_cw[1], dn_cw[1], up_cw[0], dn_cw[0]), cnt);
      chk({nm, "_cnt_sat"}, pk(up_cs[1], dn_cs[1], up_cs[0], dn_cs[0]), cnt);
   endtask

   // Event-level reference: a detent is a departure from idle and a return to idle both in the
   // same rotational sense, with no two-bit jump anywhere in between.
   logic [1:0] m_q [2];
   logic [1:0] m_first [2];
   bit         m_bad [2];
   bit         m_err [2];
   int         m_pw [2];
   int         m_ps [2];
   int         m_up [2];
   int         m_dn [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_q[i] = 2'b11; m_first[i] = 2'b11; m_bad[i] = 0; m_err[i] = 0;
         m_pw[i] = 0; m_ps[i] = 0; m_up[i] = 0; m_dn[i] = 0;
      end
   endtask

   task automatic model_step(input int ch, input logic [1:0] nq);
      logic [1:0] oq;
      oq = m_q[ch];
      if (nq != oq) begin
         if ((oq ^ nq) == 2'b11) begin
            m_bad[ch] = 1;
            m_err[ch] = 1;
         end
         if (oq == 2'b11) m_first[ch] = nq;
         if (nq == 2'b11) begin
            if (!m_bad[ch] && m_first[ch] == 2'b10 && oq == 2'b01) begin
               m_up[ch]++;
               m_pw[ch] = (m_pw[ch] + 1) % 16;
               m_ps[ch] = (m_ps[ch] < 15) ? m_ps[ch] + 1 : 15;
            end else if (!m_bad[ch] && m_first[ch] == 2'b01 && oq == 2'b10) begin
               m_dn[ch]++;
               m_pw[ch] = (m_pw[ch] + 15) % 16;
               m_ps[ch] = (m_ps[ch] > 0) ? m_ps[ch] - 1 : 0;
            end
            m_bad[ch] = 0;
         end
         m_q[ch] = nq;
      end
   endtask

   function automatic logic [1:0] cw_next(input logic [1:0] p);
      logic [1:0] r;
      case (p)
         2'b11:   r = 2'b10;
         2'b10:   r = 2'b00;
         2'b00:   r = 2'b01;
         default: r = 2'b11;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] ccw_next(input logic [1:0] p);
      logic [1:0] r;
      case (p)
         2'b11:   r = 2'b01;
         2'b01:   r = 2'b00;
         2'b00:   r = 2'b10;
         default: r = 2'b11;
      endcase
      return r;
   endfunction

   typedef struct {
      logic [1:0]  c;
      logic [1:0]  d;
      logic [7:0]  pw;
      logic [7:0]  ps;
      logic [1:0]  er;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl [16];
   bit   dir_cw [2];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, expected to have finished");
      $fatal(1);
   end

   initial begin
      // {ch1,ch0} raw levels; ch0 CW, ch1 CCW, ch0 reversal, then both CW together
      tbl[0]  = '{c:2'b11, d:2'b10, pw:8'h00, ps:8'h00, er:2'b00, cnt:pk(0,0,0,0)};
      tbl[1]  = '{c:2'b10, d:2'b10, pw:8'h00, ps:8'h00, er:2'b00, cnt:pk(0,0,0,0)};
      tbl[2]  = '{c:2'b10, d:2'b11, pw:8'h00, ps:8'h00, er:2'b00, cnt:pk(0,0,0,0)};
      tbl[3]  = '{c:2'b11, d:2'b11, pw:8'h01, ps:8'h01, er:2'b00, cnt:pk(0,0,1,0)};
      tbl[4]  = '{c:2'b01, d:2'b11, pw:8'h01, ps:8'h01, er:2'b00, cnt:pk(0,0,1,0)};
      tbl[5]  = '{c:2'b01, d:2'b01, pw:8'h01, ps:8'h01, er:2'b00, cnt:pk(0,0,1,0)};
      tbl[6]  = '{c:2'b11, d:2'b01, pw:8'h01, ps:8'h01, er:2'b00, cnt:pk(0,0,1,0)};
      tbl[7]  = '{c:2'b11, d:2'b11, pw:8'hF1, ps:8'h01, er:2'b00, cnt:pk(0,1,1,0)};
      tbl[8]  = '{c:2'b11, d:2'b10, pw:8'hF1, ps:8'h01, er:2'b00, cnt:pk(0,1,1,0)};
      tbl[9]  = '{c:2'b10, d:2'b10, pw:8'hF1, ps:8'h01, er:2'b00, cnt:pk(0,1,1,0)};
      tbl[10] = '{c:2'b11, d:2'b10, pw:8'hF1, ps:8'h01, er:2'b00, cnt:pk(0,1,1,0)};
      tbl[11] = '{c:2'b11, d:2'b11, pw:8'hF1, ps:8'h01, er:2'b00, cnt:pk(0,1,1,0)};
      tbl[12] = '{c:2'b11, d:2'b00, pw:8'hF1, ps:8'h01, er:2'b00, cnt:pk(0,1,1,0)};
      tbl[13] = '{c:2'b00, d:2'b00, pw:8'hF1, ps:8'h01, er:2'b00, cnt:pk(0,1,1,0)};
      tbl[14] = '{c:2'b00, d:2'b11, pw:8'hF1, ps:8'h01, er:2'b00, cnt:pk(0,1,1,0)};
      tbl[15] = '{c:2'b11, d:2'b11, pw:8'h02, ps:8'h12, er:2'b00, cnt:pk(1,1,2,0)};

      #2 res_n = 1'b0;
      settle(2);
      chk("rst_up", {up_w, up_s}, 4'h0);
      chk("rst_dn", {dn_w, dn_s}, 4'h0);
      chk("rst_pos", {pos_w, pos_s}, 16'h0000);
      chk("rst_err", {err_w, err_s}, 4'h0);
      res_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         rclk = tbl[i].c;
         rdt  = tbl[i].d;
         settle(20);
         chk_all($sformatf("tbl%0d", i), tbl[i].pw, tbl[i].ps, tbl[i].er, tbl[i].cnt);
      end

      // Exact pulse latency and width on a ch0 CW detent
      set_ph(0, 2'b10); settle(20);
      set_ph(0, 2'b00); settle(20);
      set_ph(0, 2'b01); settle(20);
      set_ph(0, 2'b11); settle(6);
      chk("lat_before_up", up_w, 2'b00);
      chk("lat_before_pos", pos_w, 8'h02);
      settle(1);
      chk("lat_pulse_up", up_w, 2'b01);
      chk("lat_pulse_dn", dn_w, 2'b00);
      chk("lat_pulse_pos", pos_w, 8'h03);
      chk("lat_pulse_pos_sat", pos_s, 8'h13);
      settle(1);
      chk("lat_width_up", up_w, 2'b00);
      settle(20);

      // Glitches shorter than the debounce window are invisible; one of exactly that length is not
      rdt[0] = 1'b0; settle(3); rdt[0] = 1'b1; settle(20);
      chk_all("glitch_dt", 8'h03, 8'h13, 2'b00, pk(1,1,3,0));
      set_ph(0, 2'b00); settle(3); set_ph(0, 2'b11); settle(20);
      chk_all("glitch_both3", 8'h03, 8'h13, 2'b00, pk(1,1,3,0));
      set_ph(0, 2'b00); settle(4); set_ph(0, 2'b11); settle(20);
      chk_all("glitch_both4", 8'h03, 8'h13, 2'b01, pk(1,1,3,0));
      err_clr = 1'b1; settle(1); err_clr = 1'b0;
      chk("glitch_clr", {err_w, err_s}, 4'h0);

      // Illegal jumps, with err_clr landing on the same cycle as the second one
      set_ph(0, 2'b00); settle(20);
      chk_all("illegal1", 8'h03, 8'h13, 2'b01, pk(1,1,3,0));
      set_ph(0, 2'b11); settle(6);
      err_clr = 1'b1; settle(1); err_clr = 1'b0;
      chk("illegal2_setwins", {err_w, err_s}, 4'b0101);
      settle(20);
      chk_all("illegal2", 8'h03, 8'h13, 2'b01, pk(1,1,3,0));
      err_clr = 1'b1; settle(1); err_clr = 1'b0;
      chk("lone_clr", {err_w, err_s}, 4'h0);

      // Reset in the middle of a detent on both channels
      rdt = 2'b00; settle(20);
      rclk = 2'b00; settle(10);
      #3 res_n = 1'b0;
      #1;
      chk("midrst_up_dn", {up_w, dn_w, up_s, dn_s}, 8'h00);
      chk("midrst_pos", {pos_w, pos_s}, 16'h0000);
      chk("midrst_err", {err_w, err_s}, 4'h0);
      rclk = 2'b11; rdt = 2'b11;
      settle(3);
      res_n = 1'b1;
      rdt = 2'b00; settle(20);
      rclk = 2'b00; settle(20);
      rdt = 2'b11; settle(20);
      rclk = 2'b11; settle(20);
      chk_all("after_rst", 8'h11, 8'h11, 2'b00, pk(1,0,1,0));

      // Randomised walks against the event-level model
      res_n = 1'b0; settle(2); res_n = 1'b1;
      model_reset();
      dir_cw[0] = 1; dir_cw[1] = 0;
      for (int it = 0; it < 300; it++) begin
         for (int ch = 0; ch < 2; ch++) begin
            int r;
            logic [1:0] cur, nq;
            r = $urandom_range(0, 9);
            cur = m_q[ch];
            if ($urandom_range(0, 5) == 0) dir_cw[ch] = ~dir_cw[ch];
            if (r <= 6) nq = dir_cw[ch] ? cw_next(cur) : ccw_next(cur);
            else if (r == 7) nq = dir_cw[ch] ? ccw_next(cur) : cw_next(cur);
            else if (r == 8) nq = cur;
            else nq = ~cur;
            set_ph(ch, nq);
            model_step(ch, nq);
         end
         settle($urandom_range(10, 16));
         chk_all($sformatf("rnd%0d", it), pk_pos(m_pw[1], m_pw[0]), pk_pos(m_ps[1], m_ps[0]),
                 {m_err[1], m_err[0]}, pk(m_up[1], m_dn[1], m_up[0], m_dn[0]));
         if ($urandom_range(0, 9) == 0) begin
            err_clr = 1'b1; settle(1); err_clr = 1'b0;
            m_err[0] = 0; m_err[1] = 0;
         end
      end

      chk("up_dn_exclusive", both_seen, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
